// File: rtl/scpu_inst_reload_ctrl_pkg.sv
// Shared types for the instruction reload controller: sequencer states,
// cpu_nxt bit positions and the {last, byte} FIFO entry.
package scpu_inst_reload_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_RUN,
        S_HALTED
    } state_t;

    localparam int NXT_EXHAUST = 1;
    localparam int NXT_HALT    = 0;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/scpu_inst_reload_ctrl_fifo.sv
// Synchronous show-ahead FIFO; rdata is the head entry whenever !empty.
module scpu_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             wr_en, rd_en;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/scpu_inst_reload_ctrl.sv
// Owns the shared instruction/data memory port: copies host byte batches into
// the instruction page, kicks the CPU, and reloads when it runs out.
module scpu_inst_reload_ctrl
    import scpu_inst_reload_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int PAGE_BASE  = 500,
    parameter int PAGE_BYTES = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [7:0]        host_data,
    input  logic              host_last,
    input  logic              go,
    input  logic [1:0]        cpu_nxt,
    input  logic              cpu_is_i_addr,
    input  logic [ADDR_W-1:0] cpu_i_addr,
    input  logic [ADDR_W-1:0] cpu_d_addr,
    input  logic              cpu_d_we,
    input  logic [7:0]        cpu_d_dataout,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic [7:0]        cpu_i_datain,
    output logic [7:0]        cpu_d_datain,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [7:0]        batch_cnt
);
    localparam int                KW     = $clog2(PAGE_BYTES + 1);
    localparam logic [KW-1:0]     K_FULL = KW'(PAGE_BYTES);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(PAGE_BASE);

    state_t      state;
    logic [KW-1:0] k;
    fifo_entry_t fifo_wr, fifo_rd;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;

    assign host_ready = !fifo_full && (state != S_HALTED);
    assign fifo_push  = host_valid && host_ready;
    assign fifo_wr    = '{last: host_last, data: host_data};
    // Every head byte in LOAD is consumed: written while room remains, else dropped.
    assign fifo_pop   = (state == S_LOAD) && !fifo_empty;

    scpu_byte_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wr),
        .pop   (fifo_pop),
        .rdata (fifo_rd),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= '0;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_ovf    <= 1'b0;
            batch_cnt  <= '0;
        end else begin
            cpu_start <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    state      <= S_LOAD;
                    k          <= '0;
                    cpu_enable <= 1'b1;
                    busy       <= 1'b1;
                end
                S_LOAD: if (!fifo_empty) begin
                    if (k != K_FULL) k <= k + 1'b1;
                    else             err_ovf <= 1'b1;
                    if (fifo_rd.last) begin
                        state     <= S_KICK;
                        cpu_start <= 1'b1;
                        batch_cnt <= sat_inc8(batch_cnt);
                    end
                end
                S_KICK: state <= S_RUN;
                S_RUN: begin
                    if (cpu_nxt[NXT_HALT]) begin
                        state <= S_HALTED;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cpu_nxt[NXT_EXHAUST]) begin
                        state <= S_LOAD;
                        k     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_is_i_addr ? cpu_i_addr : cpu_d_addr;
        mem_wdata = cpu_d_dataout;
        mem_we    = 1'b0;
        case (state)
            S_LOAD: begin
                mem_addr  = BASE_A + ADDR_W'(k);
                mem_wdata = fifo_rd.data;
                mem_we    = !fifo_empty && (k != K_FULL);
            end
            S_RUN, S_HALTED: mem_we = cpu_d_we;
            default: ;
        endcase
    end

    assign cpu_i_datain = cpu_is_i_addr ? mem_rdata : 8'h00;
    assign cpu_d_datain = cpu_is_i_addr ? 8'h00 : mem_rdata;

endmodule

// File: tb/tb_scpu_inst_reload_ctrl.sv
// Randomized bench: a byte-queue model of the page loader plus directed
// boot / reload / overflow / backpressure / halt / mid-load reset scenarios.
module tb_scpu_inst_reload_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       host_valid = 0, host_ready, host_last = 0, go = 0;
    logic [7:0] host_data = 0;
    logic [1:0] cpu_nxt = 0;
    logic       cpu_is_i_addr = 0, cpu_d_we = 0;
    logic [8:0] cpu_i_addr = 0, cpu_d_addr = 0;
    logic [7:0] cpu_d_dataout = 0, mem_rdata = 0;
    logic       cpu_enable, cpu_start, mem_we, busy, done, err_ovf;
    logic [7:0] cpu_i_datain, cpu_d_datain, mem_wdata, batch_cnt;
    logic [8:0] mem_addr;

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    scpu_inst_reload_ctrl dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last), .go(go), .cpu_nxt(cpu_nxt),
        .cpu_is_i_addr(cpu_is_i_addr), .cpu_i_addr(cpu_i_addr), .cpu_d_addr(cpu_d_addr),
        .cpu_d_we(cpu_d_we), .cpu_d_dataout(cpu_d_dataout), .cpu_enable(cpu_enable),
        .cpu_start(cpu_start), .cpu_i_datain(cpu_i_datain), .cpu_d_datain(cpu_d_datain),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err_ovf(err_ovf), .batch_cnt(batch_cnt)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted host byte in order; a batch is its bytes up to last.
    logic [8:0] mq[$];
    logic [8:0] me;
    int         off = 0, starts = 0, last_cyc = 0;
    bit         ended = 0, loading = 0, ovf_exp = 0, cnt_pending = 0, prev_start = 0;
    logic [7:0] exp_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            off = 0; ended = 0; loading = 0; ovf_exp = 0;
            cnt_pending = 0; prev_start = 0; starts = 0; exp_cnt = 0;
        end else begin
            if (mem_we && loading) begin
                if (mq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    me = mq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(500 + off));
                    chk("wr_data", 32'(mem_wdata), 32'(me[7:0]));
                    chk("wr_in_page", 32'(off < 12), 1);
                    off++;
                    if (me[8]) begin ended = 1; last_cyc = cyc; end
                end
            end
            if (cnt_pending) begin
                chk("batch_cnt", 32'(batch_cnt), 32'(exp_cnt));
                cnt_pending = 0;
            end
            if (cpu_start) begin
                chk("start_width", 32'(prev_start), 0);
                if (!loading) chk("start_unexpected", 1, 0);
                else begin
                    if (ended) chk("start_lat", 32'(cyc - last_cyc), 1);
                    else begin
                        while (mq.size() > 0) begin
                            me = mq.pop_front();
                            if (me[8]) break;
                        end
                        chk("ovf_writes", 32'(off), 12);
                        ovf_exp = 1;
                    end
                    chk("err_ovf", 32'(err_ovf), 32'(ovf_exp));
                    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                    cnt_pending = 1;
                    starts++;
                    loading = 0; off = 0; ended = 0;
                end
            end
            prev_start = cpu_start;
            if (host_valid && host_ready) mq.push_back({host_last, host_data});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int t = 0;
        host_valid = 1; host_data = d; host_last = l;
        @(negedge clk);
        while (!host_ready && t < 50) begin @(negedge clk); t++; end
        if (!host_ready) chk("push_timeout", 0, 1);
        step();
        host_valid = 0; host_last = 0;
    endtask

    task automatic push_batch(input int len, input int gmax);
        for (int i = 0; i < len; i++) begin
            push_byte(8'($urandom), i == len - 1);
            repeat ($urandom_range(0, gmax)) step();
        end
    endtask

    task automatic wait_start(input int n);
        int t = 0;
        do begin @(posedge clk); t++; end while (starts < n && t < 300);
        #1;
        if (starts < n) chk("start_timeout", 0, 1);
    endtask

    task automatic run_io(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_is_i_addr = 1'($urandom_range(0, 1));
            cpu_i_addr    = 9'($urandom);
            cpu_d_addr    = 9'($urandom);
            cpu_d_we      = 1'($urandom_range(0, 1));
            cpu_d_dataout = 8'($urandom);
            mem_rdata     = 8'($urandom);
            if (i == 0) begin cpu_is_i_addr = 0; cpu_d_addr = 9'd2; cpu_d_we = 1; end
            @(negedge clk);
            chk("run_addr", 32'(mem_addr), 32'(cpu_is_i_addr ? cpu_i_addr : cpu_d_addr));
            chk("run_we", 32'(mem_we), 32'(cpu_d_we));
            chk("run_wdata", 32'(mem_wdata), 32'(cpu_d_dataout));
            chk("i_datain", 32'(cpu_i_datain), 32'(cpu_is_i_addr ? mem_rdata : 8'h00));
            chk("d_datain", 32'(cpu_d_datain), 32'(cpu_is_i_addr ? 8'h00 : mem_rdata));
            step();
        end
        cpu_d_we = 0;
    endtask

    task automatic reload(input int len, input bit starve, input int nb);
        cpu_nxt = 2'b10; loading = 1;
        step();
        cpu_nxt = 2'b00;
        if (starve) begin
            repeat (2) begin
                @(negedge clk);
                chk("starve_no_wr", 32'(mem_we), 0);
                chk("starve_busy", 32'(busy), 1);
            end
            step();
            push_batch(len, 2);
        end else begin
            @(negedge clk);
            chk("reload_lat", 32'(mem_we), 1);
        end
        wait_start(nb);
    endtask

    logic [7:0] boot_b [8] = '{8'h04, 8'h3C, 8'h00, 8'h3C, 8'h05, 8'h3C, 8'h00, 8'h3C};
    int fixed_len [3] = '{8, 14, 12};

    initial begin
        int nb, t;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_enable", 32'(cpu_enable), 0);
        chk("rst_start", 32'(cpu_start), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(err_ovf), 0);
        chk("rst_cnt", 32'(batch_cnt), 0);
        chk("rst_ready", 32'(host_ready), 1);
        step();

        // Boot with the batch pre-queued.
        for (int i = 0; i < 8; i++) push_byte(boot_b[i], i == 7);
        go = 1; loading = 1;
        step();
        go = 0;
        @(negedge clk);
        chk("boot_lat", 32'(mem_we), 1);
        chk("boot_enable", 32'(cpu_enable), 1);
        chk("boot_busy", 32'(busy), 1);
        wait_start(1);
        nb = 1;
        run_io(4);

        // Reload: fixed boundary lengths first, then random lengths and modes.
        for (int b = 0; b < 8; b++) begin
            int len;
            bit starve;
            len    = (b < 3) ? fixed_len[b] : $urandom_range(1, 16);
            starve = (b < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!starve) push_batch(len, 1);
            nb++;
            reload(len, starve, nb);
            run_io(3);
        end

        // Backpressure: 16 queued bytes fill the FIFO, a 17th is refused.
        push_batch(16, 0);
        host_valid = 1; host_data = 8'hEE; host_last = 1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_ready", 32'(host_ready), 0);
            step();
        end
        host_valid = 0; host_last = 0;
        nb++;
        reload(16, 0, nb);
        chk("ovf_sticky", 32'(err_ovf), 1);

        // Halt has priority over exhaust.
        cpu_is_i_addr = 1; cpu_i_addr = 9'h0A5; cpu_nxt = 2'b11;
        step();
        cpu_nxt = 2'b00;
        @(negedge clk);
        chk("halt_done", 32'(done), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_start", 32'(cpu_start), 0);
        step();
        host_valid = 1; host_data = 8'h11; host_last = 1;
        for (int i = 0; i < 3; i++) begin
            cpu_i_addr = 9'($urandom);
            @(negedge clk);
            chk("halt_ready", 32'(host_ready), 0);
            chk("halt_we", 32'(mem_we), 0);
            chk("halt_addr", 32'(mem_addr), 32'(cpu_i_addr));
            chk("halt_done_hold", 32'(done), 1);
            step();
        end
        host_valid = 0; host_last = 0;

        // Reset out of HALTED, then abort a load after three writes.
        rst = 1; step(); rst = 0;
        push_batch(8, 0);
        go = 1; loading = 1;
        step();
        go = 0;
        t = 0;
        while (off < 3 && t < 40) begin @(posedge clk); t++; end
        chk("mid_load_writes", 32'(off), 3);
        #1 rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("abort_enable", 32'(cpu_enable), 0);
        chk("abort_start", 32'(cpu_start), 0);
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ovf", 32'(err_ovf), 0);
        chk("abort_cnt", 32'(batch_cnt), 0);
        chk("abort_ready", 32'(host_ready), 1);
        step();
        // Flushed FIFO: go yields an empty LOAD until a new byte arrives at 500.
        go = 1; loading = 1;
        step();
        go = 0;
        repeat (3) begin
            @(negedge clk);
            chk("flushed_no_wr", 32'(mem_we), 0);
        end
        step();
        push_byte(8'hA5, 1);
        wait_start(1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/scpu_inst_reload_ctrl.md
Name: scpu_inst_reload_ctrl

Overview:
Sequencer and memory-port owner between a host byte stream, SERIAL_CPU_8BIT and I_MEMORY_8BIT. It buffers instruction bytes from the host and writes each batch into the instruction page of the shared 9-bit memory. It then pulses the CPU start input and hands the memory port back to the CPU. On cpu_nxt[1] (instructions exhausted) it reloads the next batch; on cpu_nxt[0] (HALT) it finishes.

Parameters:
ADDR_W, 9, memory address width
PAGE_BASE, 500, first byte address of the instruction page (PC 250 × 2)
PAGE_BYTES, 12, page capacity in bytes; PAGE_BASE+PAGE_BYTES-1 must not exceed 2^ADDR_W-1
FIFO_DEPTH, 16, host byte FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
host_valid  in  1  host byte valid
host_ready  out  1  FIFO not full
host_data  in  8  instruction byte (low byte of each instruction first)
host_last  in  1  marks final byte of a batch
go  in  1  one-cycle boot request; sampled in IDLE only
cpu_nxt  in  2  [1]=instructions exhausted, [0]=halted
cpu_is_i_addr  in  1  CPU address select
cpu_i_addr  in  ADDR_W  CPU instruction address
cpu_d_addr  in  ADDR_W  CPU data address
cpu_d_we  in  1  CPU data write enable
cpu_d_dataout  in  8  CPU write data
cpu_enable  out  1  CPU enable
cpu_start  out  1  one-cycle CPU start pulse
cpu_i_datain  out  8  mem_rdata when cpu_is_i_addr, else 0
cpu_d_datain  out  8  mem_rdata when !cpu_is_i_addr, else 0
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data
busy  out  1  state not IDLE/HALTED
done  out  1  CPU halted
err_ovf  out  1  sticky: batch exceeded PAGE_BYTES
batch_cnt  out  8  batches loaded, saturating at 255

Behaviour:
- Reset: state=IDLE; FIFO flushed; outputs cpu_enable, cpu_start, mem_we, busy, done, err_ovf and batch_cnt are 0; host_ready=1 on the cycle after reset releases. Memory contents are untouched. Reset applied mid-operation aborts immediately with the same values.
- FIFO: 9-bit entries {last, byte}, show-ahead. Push when host_valid&&host_ready. Push and pop in the same cycle are legal, including when full. FIFO accepts bytes in every state except HALTED, where host_ready=0.
- States:
  - IDLE: go → LOAD with cpu_enable=1 (held until reset); k=0.
  - LOAD: each cycle with FIFO non-empty, pop and write: mem_we=1, mem_addr=PAGE_BASE+k, mem_wdata=byte, k++. One byte per cycle; FIFO empty inserts bubbles with mem_we=0. The write of a last byte → KICK.
    - If k reaches PAGE_BYTES before last: no further writes; err_ovf=1; remaining bytes through last are popped and discarded (one per cycle); then KICK.
    - Odd byte count is not checked.
  - KICK: cpu_start=1 for exactly this cycle; batch_cnt++; → RUN.
  - RUN: memory port owned by CPU. mem_addr = cpu_is_i_addr ? cpu_i_addr : cpu_d_addr; mem_we=cpu_d_we; mem_wdata=cpu_d_dataout. cpu_nxt[0] → HALTED (priority over [1]). cpu_nxt[1] → LOAD, k=0.
  - HALTED: done=1; port remains with CPU; exits only via reset.
- Ownership: in IDLE and LOAD, cpu_d_we is ignored and mem_we comes from the loader only. The read-data muxes to the CPU are combinational in all states.
- Latency: go → first write 1 cycle (FIFO non-empty); last write → cpu_start 1 cycle; cpu_nxt[1] → first reload write 1 cycle.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, KICK, RUN, HALTED) and NXT_EXHAUST=1, NXT_HALT=0 bit indices.
- Sub-module: scpu_byte_fifo, a synchronous show-ahead FIFO parameterised on width and depth.

Test Plan:
- Boot: push 8 bytes (04 3C, 00 3C, ... last on 8th), pulse go → mem_we on 8 consecutive cycles, addr 500..507 with matching data; cpu_start high exactly 1 cycle later; batch_cnt=1.
- Reload: in RUN, 8-byte batch queued, cpu_nxt=2'b10 → writes 500..507; new start pulse; batch_cnt=2; CPU writes during RUN pass through (cpu_d_addr=2, cpu_d_we=1 → mem_addr=2, mem_we=1).
- Halt: cpu_nxt=2'b11 in RUN → HALTED, done=1, no writes, no cpu_start, host_ready=0; mem_addr tracks cpu_i_addr when cpu_is_i_addr=1.
- Overflow: 14-byte batch → 12 writes 500..511; err_ovf=1; 2 bytes discarded; cpu_start still pulses; next batch lands at 500.
- Backpressure/starve: push 17 bytes while RUN → host_ready=0 after 16. Separately, cpu_nxt[1] with FIFO empty → LOAD with no writes until the next byte arrives, then addr 500.
- Reset mid-LOAD after 3 writes → next cycle all outputs 0, state IDLE, FIFO empty, host_ready=1.
